// File: rtl/sync_arith_pkg.sv
// -----------------------------------------------------------------------------
// sync_arith_pkg
// Shared definitions for the synchronous arithmetic unit driver:
//   - op code constants driven onto the arithmetic unit
//   - bit positions inside the 4-bit status word
//   - driver FSM state encoding
// -----------------------------------------------------------------------------
package sync_arith_pkg;

   localparam logic [1:0] OP_KONW  = 2'b00;
   localparam logic [1:0] OP_PORO  = 2'b01;
   localparam logic [1:0] OP_USTAW = 2'b10;
   localparam logic [1:0] OP_PRZES = 2'b11;

   localparam int ST_ERROR         = 3;
   localparam int ST_NOT_EVEN_ZERO = 2;
   localparam int ST_ZEROS         = 1;
   localparam int ST_OVERFLOW      = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } drv_state_t;

endpackage

// File: rtl/sync_arith_driver_status_check.sv
// -----------------------------------------------------------------------------
// status_check
// Combinational consistency check of an arithmetic-unit status word against
// the result it accompanies.
// Ports:
//   i_result   : BITS-wide result
//   i_status   : {ERROR, NOT_EVEN_ZERO, ZEROS, OVERFLOW}
//   o_mismatch : 1 when ZEROS, NOT_EVEN_ZERO or OVERFLOW disagree with result
// ERROR is not part of the check.
// -----------------------------------------------------------------------------
module status_check
   import sync_arith_pkg::*;
#(
   parameter int BITS   = 12,
   parameter int STAT_W = 4
) (
   input  logic signed [BITS-1:0]   i_result,
   input  logic        [STAT_W-1:0] i_status,
   output logic                     o_mismatch
);

   logic w_zero;
   logic w_odd_zeros;
   logic w_unused;

   assign w_zero      = (i_result == '0);
   // Parity of the inverted word is 1 when the number of 0-bits is odd.
   assign w_odd_zeros = ^(~i_result);

   assign o_mismatch = (i_status[ST_ZEROS] != w_zero)
                     | (i_status[ST_NOT_EVEN_ZERO] != w_odd_zeros)
                     | i_status[ST_OVERFLOW];

   assign w_unused = i_status[ST_ERROR];

endmodule

// File: rtl/sync_arith_driver.sv
// -----------------------------------------------------------------------------
// sync_arith_driver
// Initiator-side sequencer for the synchronous arithmetic unit. Accepts a
// command, drives it to the unit, waits LAT cycles, captures and checks the
// result/status and returns a tagged response.
// Ports:
//   i_clk, i_reset                  : clock, async active-high reset
//   i_cmd_valid/o_cmd_ready         : command handshake
//   i_cmd_op, i_cmd_A, i_cmd_B      : command payload
//   o_alu_A, o_alu_B, o_alu_op      : registered operands/op to the unit
//   i_alu_result, i_alu_status      : unit outputs, sampled at capture edge
//   o_rsp_valid/i_rsp_ready         : response handshake
//   o_rsp_result/status/op/tag      : captured response payload
//   o_rsp_mismatch                  : status inconsistent with result
//   o_err_count                     : saturating count of ERROR responses
//   o_busy                          : FSM not in IDLE
// -----------------------------------------------------------------------------
module sync_arith_driver
   import sync_arith_pkg::*;
#(
   parameter int BITS   = 12,
   parameter int OP_W   = 2,
   parameter int STAT_W = 4,
   parameter int LAT    = 1,
   parameter int CNT_W  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic        [OP_W-1:0]   i_cmd_op,
   input  logic signed [BITS-1:0]   i_cmd_A,
   input  logic signed [BITS-1:0]   i_cmd_B,
   output logic signed [BITS-1:0]   o_alu_A,
   output logic signed [BITS-1:0]   o_alu_B,
   output logic        [OP_W-1:0]   o_alu_op,
   input  logic signed [BITS-1:0]   i_alu_result,
   input  logic        [STAT_W-1:0] i_alu_status,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic signed [BITS-1:0]   o_rsp_result,
   output logic        [STAT_W-1:0] o_rsp_status,
   output logic        [OP_W-1:0]   o_rsp_op,
   output logic        [3:0]        o_rsp_tag,
   output logic                     o_rsp_mismatch,
   output logic        [CNT_W-1:0]  o_err_count,
   output logic                     o_busy
);

   localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;

   drv_state_t       r_state;
   drv_state_t       w_next;
   logic [WC_W-1:0]  r_wcnt;
   logic [3:0]       r_tag;
   logic [3:0]       r_cur_tag;
   logic             w_accept;
   logic             w_capture;
   logic             w_mismatch;

   status_check #(
      .BITS   (BITS),
      .STAT_W (STAT_W)
   ) u_status_check (
      .i_result   (i_alu_result),
      .i_status   (i_alu_status),
      .o_mismatch (w_mismatch)
   );

   assign w_accept  = (r_state == IDLE) && i_cmd_valid;
   assign w_capture = (r_state == WAIT) && (r_wcnt == '0);

   // Handshake outputs decode state only, so no path from i_cmd_valid.
   assign o_cmd_ready = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_rsp_valid = (r_state == RESP);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_cmd_valid) w_next = ISSUE;
         ISSUE:   w_next = WAIT;
         WAIT:    if (r_wcnt == '0) w_next = RESP;
         RESP:    if (i_rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_alu_A        <= '0;
         o_alu_B        <= '0;
         o_alu_op       <= '0;
         r_cur_tag      <= '0;
         r_tag          <= '0;
         r_wcnt         <= '0;
         o_rsp_result   <= '0;
         o_rsp_status   <= '0;
         o_rsp_op       <= '0;
         o_rsp_tag      <= '0;
         o_rsp_mismatch <= 1'b0;
         o_err_count    <= '0;
      end else begin
         if (w_accept) begin
            o_alu_A   <= i_cmd_A;
            o_alu_B   <= i_cmd_B;
            o_alu_op  <= i_cmd_op;
            r_cur_tag <= r_tag;
         end

         if (r_state == ISSUE)
            r_wcnt <= WC_W'(LAT - 1);
         else if ((r_state == WAIT) && (r_wcnt != '0))
            r_wcnt <= r_wcnt - 1'b1;

         // o_rsp_* only move here, so they are frozen for the whole RESP phase.
         if (w_capture) begin
            o_rsp_result   <= i_alu_result;
            o_rsp_status   <= i_alu_status;
            o_rsp_op       <= o_alu_op;
            o_rsp_tag      <= r_cur_tag;
            o_rsp_mismatch <= w_mismatch;
            r_tag          <= r_tag + 4'd1;
            if (i_alu_status[ST_ERROR] && (o_err_count != '1))
               o_err_count <= o_err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_arith_driver.sv
module tb_sync_arith_driver;

   logic        clk;
   logic        rst;

   // LAT=1 instance signals
   logic        c_valid;
   logic [1:0]  c_op;
   logic [11:0] c_A, c_B;
   logic [11:0] a_res;
   logic [3:0]  a_stat;
   logic        r_ready;
   logic        cmd_ready, rsp_valid, rsp_mis, busy;
   logic [11:0] alu_A, alu_B, rsp_res;
   logic [1:0]  alu_op, rsp_op;
   logic [3:0]  rsp_stat, rsp_tag;
   logic [7:0]  err_cnt;

   // LAT=3 instance signals
   logic        d_valid;
   logic [1:0]  d_op;
   logic [11:0] d_A, d_B;
   logic [11:0] d_res;
   logic [3:0]  d_stat;
   logic        d_ready;
   logic        d_cmd_ready, d_rsp_valid, d_rsp_mis, d_busy;
   logic [11:0] d_alu_A, d_alu_B, d_rsp_res;
   logic [1:0]  d_alu_op, d_rsp_op;
   logic [3:0]  d_rsp_stat, d_rsp_tag;
   logic [7:0]  d_err_cnt;

   int n_vec  = 0;
   int n_fail = 0;
   logic [3:0] exp_tag;
   int         exp_err;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] res;
      logic [3:0]  st;
      logic        mis;
   } vec_t;
   vec_t tbl[9];

   sync_arith_driver #(.BITS(12), .OP_W(2), .STAT_W(4), .LAT(1), .CNT_W(8)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cmd_valid(c_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_op(c_op), .i_cmd_A(c_A), .i_cmd_B(c_B),
      .o_alu_A(alu_A), .o_alu_B(alu_B), .o_alu_op(alu_op),
      .i_alu_result(a_res), .i_alu_status(a_stat),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(r_ready),
      .o_rsp_result(rsp_res), .o_rsp_status(rsp_stat), .o_rsp_op(rsp_op),
      .o_rsp_tag(rsp_tag), .o_rsp_mismatch(rsp_mis),
      .o_err_count(err_cnt), .o_busy(busy)
   );

   sync_arith_driver #(.BITS(12), .OP_W(2), .STAT_W(4), .LAT(3), .CNT_W(8)) dut3 (
      .i_clk(clk), .i_reset(rst),
      .i_cmd_valid(d_valid), .o_cmd_ready(d_cmd_ready),
      .i_cmd_op(d_op), .i_cmd_A(d_A), .i_cmd_B(d_B),
      .o_alu_A(d_alu_A), .o_alu_B(d_alu_B), .o_alu_op(d_alu_op),
      .i_alu_result(d_res), .i_alu_status(d_stat),
      .o_rsp_valid(d_rsp_valid), .i_rsp_ready(d_ready),
      .o_rsp_result(d_rsp_res), .o_rsp_status(d_rsp_stat), .o_rsp_op(d_rsp_op),
      .o_rsp_tag(d_rsp_tag), .o_rsp_mismatch(d_rsp_mis),
      .o_err_count(d_err_cnt), .o_busy(d_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Entered at a negedge in an IDLE cycle; returns at a negedge in IDLE.
   task automatic xact(input logic [1:0] op, input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] res, input logic [3:0] st, input logic mis);
      chk("idle_cmd_ready", cmd_ready, 1);
      c_valid = 1'b1; c_op = op; c_A = a; c_B = b;
      a_res = ~res; a_stat = ~st;
      @(negedge clk);                       // ISSUE
      c_valid = 1'b0; c_op = ~op; c_A = ~a; c_B = ~b;
      chk("issue_alu_op", alu_op, op);
      chk("issue_alu_A", alu_A, a);
      chk("issue_alu_B", alu_B, b);
      chk("issue_cmd_ready", cmd_ready, 0);
      chk("issue_busy", busy, 1);
      chk("issue_rsp_valid", rsp_valid, 0);
      @(negedge clk);                       // WAIT (last and only)
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_alu_A", alu_A, a);
      a_res = res; a_stat = st;
      @(negedge clk);                       // RESP
      a_res = ~res; a_stat = ~st;
      if (st[3] && exp_err < 255) exp_err++;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_res, res);
      chk("rsp_status", rsp_stat, st);
      chk("rsp_op", rsp_op, op);
      chk("rsp_tag", rsp_tag, exp_tag);
      chk("rsp_mismatch", rsp_mis, mis);
      chk("err_count", err_cnt, exp_err);
      exp_tag = exp_tag + 4'd1;
      r_ready = 1'b1;
      @(negedge clk);                       // IDLE again
      r_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
   endtask

   initial begin
      tbl[0] = '{2'b01, 12'd5,   12'd3,   12'h001, 4'b0100, 1'b0};
      tbl[1] = '{2'b00, 12'd0,   12'd0,   12'h000, 4'b0000, 1'b1};
      tbl[2] = '{2'b10, 12'hFFF, 12'h001, 12'hFFF, 4'b0000, 1'b0};
      tbl[3] = '{2'b11, 12'h800, 12'h7FF, 12'h000, 4'b0010, 1'b0};
      tbl[4] = '{2'b01, 12'h123, 12'h456, 12'h001, 4'b0101, 1'b1};
      tbl[5] = '{2'b00, 12'h0AA, 12'h055, 12'h003, 4'b1000, 1'b0};
      tbl[6] = '{2'b10, 12'h7FF, 12'h7FF, 12'h007, 4'b1100, 1'b0};
      tbl[7] = '{2'b11, 12'h800, 12'h800, 12'h800, 4'b0100, 1'b0};
      tbl[8] = '{2'b01, 12'h010, 12'h020, 12'h0F0, 4'b0110, 1'b1};

      rst = 1'b1; c_valid = 0; c_op = 0; c_A = 0; c_B = 0; a_res = 0; a_stat = 0; r_ready = 0;
      d_valid = 0; d_op = 0; d_A = 0; d_B = 0; d_res = 0; d_stat = 0; d_ready = 0;
      exp_tag = 4'd0; exp_err = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err_count", err_cnt, 0);
      chk("rst_alu_A", alu_A, 0);
      chk("rst_rsp_tag", rsp_tag, 0);

      // table vectors
      for (int i = 0; i < 9; i++)
         xact(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].st, tbl[i].mis);

      // back-pressure: hold RESP 5 cycles with a pending command and noisy ALU inputs
      c_valid = 1'b1; c_op = 2'b10; c_A = 12'h7FF; c_B = 12'h800;
      a_res = 12'h001; a_stat = 4'b0100;
      @(negedge clk);
      c_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      a_res = 12'hABC; a_stat = 4'b1011;
      c_valid = 1'b1; c_op = 2'b00; c_A = 12'h111; c_B = 12'h222;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_result", rsp_res, 12'h001);
         chk("bp_hold_status", rsp_stat, 4'b0100);
         chk("bp_hold_op", rsp_op, 2'b10);
         chk("bp_hold_tag", rsp_tag, exp_tag);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_alu_A", alu_A, 12'h7FF);
      end
      exp_tag = exp_tag + 4'd1;
      r_ready = 1'b1;                       // c_valid still high across the handshake edge
      @(negedge clk);
      r_ready = 1'b0; c_valid = 1'b0;
      chk("bp_release_ready", cmd_ready, 1);
      chk("bp_release_busy", busy, 0);
      chk("bp_release_valid", rsp_valid, 0);
      chk("bp_err_count", err_cnt, exp_err);

      // reset during WAIT
      c_valid = 1'b1; c_op = 2'b01; c_A = 12'h00F; c_B = 12'h0F0;
      a_res = 12'h001; a_stat = 4'b1100;
      @(negedge clk);
      c_valid = 1'b0;
      @(negedge clk);
      chk("midrst_in_wait", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_alu_A", alu_A, 0);
      chk("midrst_err", err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_rsp", rsp_valid, 0);
      end
      exp_tag = 4'd0; exp_err = 0;

      // 260 back-to-back ERROR responses: tag wrap and counter saturation
      for (int i = 0; i < 260; i++)
         xact(2'(i), 12'(i), 12'(~i), 12'hFFF, 4'b1000, 1'b0);
      chk("err_saturated", err_cnt, 8'd255);

      // LAT=3 instance
      d_valid = 1'b1; d_op = 2'b11; d_A = 12'h123; d_B = 12'hFED;
      d_res = 12'h555; d_stat = 4'b0001;
      @(negedge clk);                       // ISSUE
      d_valid = 1'b0; d_A = 12'h000;
      chk("l3_alu_op", d_alu_op, 2'b11);
      chk("l3_alu_A", d_alu_A, 12'h123);
      chk("l3_alu_B", d_alu_B, 12'hFED);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);                    // WAIT cycles
         chk("l3_wait_valid", d_rsp_valid, 0);
         chk("l3_wait_alu_A", d_alu_A, 12'h123);
         chk("l3_wait_alu_B", d_alu_B, 12'hFED);
         if (i == 2) begin d_res = 12'h0F0; d_stat = 4'b0000; end
      end
      @(negedge clk);                       // 5 cycles after accept
      d_res = 12'h555; d_stat = 4'b0001;
      chk("l3_rsp_valid", d_rsp_valid, 1);
      chk("l3_rsp_result", d_rsp_res, 12'h0F0);
      chk("l3_rsp_status", d_rsp_stat, 4'b0000);
      chk("l3_rsp_mis", d_rsp_mis, 0);
      chk("l3_rsp_tag", d_rsp_tag, 0);
      chk("l3_rsp_op", d_rsp_op, 2'b11);
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      chk("l3_back_idle", d_cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
